// File: rtl/sync_barrier_release_stage_if.sv
// -----------------------------------------------------------------------------
// sync_barrier_release_stage_if
// Bundles the signals of the barrier release stage into one interface:
//   acc_*      account message from the previous stage (valid/ready)
//   mem_rd_*   barrier-table read result for the account offered this cycle
//   mem_wr_*   registered barrier-table write-back
//   rel_*      release message towards the virtual network (valid/ready)
//   err_dup    duplicate-arrival pulse (only active with SYNC_DUP_CHECK_EN)
//
// Handshake rule for both acc_* and rel_*: a transfer happens on a rising
// clock edge where valid && ready are both 1. The payload must be stable
// while valid is 1 and ready is 0. Ready never depends combinationally on
// the valid of the same channel.
//
// Modports:
//   master : the release stage itself (drives acc_ready, mem_wr_*, rel_*)
//   slave  : the surrounding logic (drives accounts, table reads, rel_ready)
// -----------------------------------------------------------------------------
interface sync_barrier_release_stage_if #(
  parameter int TILE_COUNT   = 16,
  parameter int BARRIER_ID_W = 6,
  parameter int CNT_W        = 10
);
  localparam int SRC_W = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

  logic                    acc_valid;
  logic [BARRIER_ID_W-1:0] acc_barrier_id;
  logic [SRC_W-1:0]        acc_tile_src;
  logic [CNT_W-1:0]        acc_cnt_setup;
  logic                    acc_ready;

  logic                    mem_hit;
  logic [CNT_W-1:0]        mem_rd_cnt;
  logic [TILE_COUNT-1:0]   mem_rd_mask;
  logic                    mem_wr_en;
  logic [BARRIER_ID_W-1:0] mem_wr_id;
  logic [CNT_W-1:0]        mem_wr_cnt;
  logic [TILE_COUNT-1:0]   mem_wr_mask;
  logic                    mem_wr_free;

  logic                    rel_valid;
  logic [BARRIER_ID_W-1:0] rel_barrier_id;
  logic [TILE_COUNT-1:0]   rel_dest_mask;
  logic                    rel_ready;

  logic                    err_dup;

  modport master (
    input  acc_valid, acc_barrier_id, acc_tile_src, acc_cnt_setup,
    output acc_ready,
    input  mem_hit, mem_rd_cnt, mem_rd_mask,
    output mem_wr_en, mem_wr_id, mem_wr_cnt, mem_wr_mask, mem_wr_free,
    output rel_valid, rel_barrier_id, rel_dest_mask,
    input  rel_ready,
    output err_dup
  );

  modport slave (
    output acc_valid, acc_barrier_id, acc_tile_src, acc_cnt_setup,
    input  acc_ready,
    output mem_hit, mem_rd_cnt, mem_rd_mask,
    input  mem_wr_en, mem_wr_id, mem_wr_cnt, mem_wr_mask, mem_wr_free,
    input  rel_valid, rel_barrier_id, rel_dest_mask,
    output rel_ready,
    input  err_dup
  );
endinterface

// File: rtl/sync_barrier_release_stage.sv
// -----------------------------------------------------------------------------
// sync_barrier_release_stage
// Final stage of the barrier synchronization core. Each accepted account
// message is combined with the barrier-table read for it (or with the write
// still in flight for the same barrier), the counter/mask are updated and
// written back one cycle later, and the last arrival pushes a release message
// {barrier id, destination mask} into a small FIFO that drains to the network.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    sync_barrier_release_stage_if.master (account, table, release)
//
// Optional feature: define SYNC_DUP_CHECK_EN to drop duplicate arrivals of a
// tile on an existing barrier and pulse err_dup; otherwise err_dup is 0 and
// duplicates decrement like any other arrival.
// -----------------------------------------------------------------------------
module sync_barrier_release_stage #(
  parameter int TILE_COUNT     = 16,
  parameter int BARRIER_ID_W   = 6,
  parameter int CNT_W          = 10,
  parameter int REL_FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  sync_barrier_release_stage_if.master bus
);
  localparam int PTR_W  = $clog2(REL_FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int ENT_W  = BARRIER_ID_W + TILE_COUNT;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(REL_FIFO_DEPTH);

  // Registered table write (also the forwarding source for the next account)
  logic                    wr_en_q,   wr_en_d;
  logic [BARRIER_ID_W-1:0] wr_id_q,   wr_id_d;
  logic [CNT_W-1:0]        wr_cnt_q,  wr_cnt_d;
  logic [TILE_COUNT-1:0]   wr_mask_q, wr_mask_d;
  logic                    wr_free_q, wr_free_d;

  // Release FIFO
  logic [ENT_W-1:0]  fifo_mem [REL_FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] count_q,  count_d;
  logic [ENT_W-1:0]  head;

  logic                    acc_ready;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fwd;
  logic                    eff_hit;
  logic [CNT_W-1:0]        eff_cnt;
  logic [TILE_COUNT-1:0]   eff_mask;
  logic [TILE_COUNT-1:0]   src_onehot;
  logic [CNT_W-1:0]        new_cnt;
  logic [TILE_COUNT-1:0]   new_mask;
  logic                    release_hit;
  logic                    dup_hit;

`ifdef SYNC_DUP_CHECK_EN
  logic dup_q, dup_d;
`endif

  // Ready uses only the registered count, so it never depends on rel_ready.
  // It is also held low while reset is asserted so every output reads 0.
  assign acc_ready = reset && (count_q < DEPTH_C);
  assign accept    = bus.acc_valid && acc_ready;
  assign pop       = (count_q != '0) && bus.rel_ready;
  assign head      = fifo_mem[rd_ptr_q];

  always_comb begin
    src_onehot  = TILE_COUNT'(1) << bus.acc_tile_src;

    // A write still in flight for the same barrier is newer than the table
    // read; a forwarded entry that was just freed behaves like a miss.
    fwd         = wr_en_q && (wr_id_q == bus.acc_barrier_id);
    eff_hit     = fwd ? !wr_free_q : bus.mem_hit;
    eff_cnt     = fwd ? wr_cnt_q   : bus.mem_rd_cnt;
    eff_mask    = fwd ? wr_mask_q  : bus.mem_rd_mask;

    new_cnt     = bus.acc_cnt_setup;
    new_mask    = src_onehot;
    if (eff_hit) begin
      new_cnt  = (eff_cnt == '0) ? '0 : eff_cnt - CNT_W'(1);
      new_mask = eff_mask | src_onehot;
    end
    release_hit = (new_cnt == '0);

`ifdef SYNC_DUP_CHECK_EN
    dup_hit     = eff_hit && ((eff_mask & src_onehot) != '0);
`else
    dup_hit     = 1'b0;
`endif
  end

  assign push = accept && !dup_hit && release_hit;

  always_comb begin
    wr_en_d   = accept && !dup_hit;
    wr_id_d   = wr_id_q;
    wr_cnt_d  = wr_cnt_q;
    wr_mask_d = wr_mask_q;
    wr_free_d = wr_free_q;
    if (accept && !dup_hit) begin
      wr_id_d   = bus.acc_barrier_id;
      wr_cnt_d  = new_cnt;
      wr_mask_d = new_mask;
      wr_free_d = release_hit;
    end
`ifdef SYNC_DUP_CHECK_EN
    dup_d     = accept && dup_hit;
`endif
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d   = count_q + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_id_q   <= '0;
      wr_cnt_q  <= '0;
      wr_mask_q <= '0;
      wr_free_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
`ifdef SYNC_DUP_CHECK_EN
      dup_q     <= 1'b0;
`endif
    end else begin
      wr_en_q   <= wr_en_d;
      wr_id_q   <= wr_id_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_mask_q <= wr_mask_d;
      wr_free_q <= wr_free_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
`ifdef SYNC_DUP_CHECK_EN
      dup_q     <= dup_d;
`endif
    end
  end

  // FIFO storage needs no reset: its contents are only visible while the
  // registered count says the entry is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.acc_barrier_id, new_mask};
    end
  end

  assign bus.acc_ready      = acc_ready;
  assign bus.mem_wr_en      = wr_en_q;
  assign bus.mem_wr_id      = wr_id_q;
  assign bus.mem_wr_cnt     = wr_cnt_q;
  assign bus.mem_wr_mask    = wr_mask_q;
  assign bus.mem_wr_free    = wr_free_q;
  assign bus.rel_valid      = (count_q != '0);
  assign bus.rel_barrier_id = (count_q != '0) ? head[ENT_W-1:TILE_COUNT] : '0;
  assign bus.rel_dest_mask  = (count_q != '0) ? head[TILE_COUNT-1:0] : '0;
`ifdef SYNC_DUP_CHECK_EN
  assign bus.err_dup        = dup_q;
`else
  assign bus.err_dup        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_barrier_release_stage.sv
// -----------------------------------------------------------------------------
// tb_sync_barrier_release_stage
// Directed bench for sync_barrier_release_stage. A queue-based model of the
// barrier rules runs alongside the DUT and every cycle's outputs are compared
// against it; literal expectations at key points pin the model itself.
// Inputs change on the falling edge; the DUT and model sample on the rising
// edge; outputs are compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_sync_barrier_release_stage;
  localparam int TILE_COUNT     = 16;
  localparam int BARRIER_ID_W   = 6;
  localparam int CNT_W          = 10;
  localparam int REL_FIFO_DEPTH = 4;
  localparam int ENT_W          = BARRIER_ID_W + TILE_COUNT;
`ifdef SYNC_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  sync_barrier_release_stage_if #(
    .TILE_COUNT(TILE_COUNT), .BARRIER_ID_W(BARRIER_ID_W), .CNT_W(CNT_W)
  ) bus_if ();

  sync_barrier_release_stage #(
    .TILE_COUNT(TILE_COUNT), .BARRIER_ID_W(BARRIER_ID_W),
    .CNT_W(CNT_W), .REL_FIFO_DEPTH(REL_FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [ENT_W-1:0]        exp_q[$];   // releases expected, in push order
  logic                    m_wr_en;
  logic [BARRIER_ID_W-1:0] m_wr_id;
  logic [CNT_W-1:0]        m_wr_cnt;
  logic [TILE_COUNT-1:0]   m_wr_mask;
  logic                    m_wr_free;
  logic                    m_dup;
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr_en   = 1'b0;
    m_wr_id   = '0;
    m_wr_cnt  = '0;
    m_wr_mask = '0;
    m_wr_free = 1'b0;
    m_dup     = 1'b0;
  endtask

  // One rising edge of the barrier rules, from the inputs alone.
  task automatic model_step();
    logic                  ready, acc, pop, hit, dup;
    logic [CNT_W-1:0]      cnt, nc;
    logic [TILE_COUNT-1:0] mask, oh, nm;
    ready = (exp_q.size() < REL_FIFO_DEPTH);
    acc   = bus_if.acc_valid && ready;
    pop   = (exp_q.size() != 0) && bus_if.rel_ready;
    if (m_wr_en && (m_wr_id == bus_if.acc_barrier_id)) begin
      hit = !m_wr_free; cnt = m_wr_cnt; mask = m_wr_mask;
    end else begin
      hit = bus_if.mem_hit; cnt = bus_if.mem_rd_cnt; mask = bus_if.mem_rd_mask;
    end
    oh  = '0;
    oh[bus_if.acc_tile_src] = 1'b1;
    dup = DUP_EN && hit && ((mask & oh) != 0);
    if (hit) begin
      nc = (cnt == 0) ? '0 : cnt - 1'b1;
      nm = mask | oh;
    end else begin
      nc = bus_if.acc_cnt_setup;
      nm = oh;
    end
    if (pop) void'(exp_q.pop_front());
    m_wr_en = acc && !dup;
    m_dup   = acc && dup;
    if (acc && !dup) begin
      m_wr_id   = bus_if.acc_barrier_id;
      m_wr_cnt  = nc;
      m_wr_mask = nm;
      m_wr_free = (nc == 0);
      if (nc == 0) exp_q.push_back({bus_if.acc_barrier_id, nm});
    end
  endtask

  task automatic compare();
    chk("acc_ready", 32'(bus_if.acc_ready), 32'(exp_q.size() < REL_FIFO_DEPTH));
    chk("rel_valid", 32'(bus_if.rel_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("rel_barrier_id", 32'(bus_if.rel_barrier_id), 32'(exp_q[0][ENT_W-1:TILE_COUNT]));
      chk("rel_dest_mask",  32'(bus_if.rel_dest_mask),  32'(exp_q[0][TILE_COUNT-1:0]));
    end
    chk("mem_wr_en", 32'(bus_if.mem_wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("mem_wr_id",   32'(bus_if.mem_wr_id),   32'(m_wr_id));
      chk("mem_wr_cnt",  32'(bus_if.mem_wr_cnt),  32'(m_wr_cnt));
      chk("mem_wr_mask", 32'(bus_if.mem_wr_mask), 32'(m_wr_mask));
      chk("mem_wr_free", 32'(bus_if.mem_wr_free), 32'(m_wr_free));
    end
    chk("err_dup", 32'(bus_if.err_dup), 32'(m_dup));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_acc(input int id, input int src, input int setup,
                           input bit hit, input int rcnt, input int rmask);
    bus_if.acc_valid      = 1'b1;
    bus_if.acc_barrier_id = BARRIER_ID_W'(id);
    bus_if.acc_tile_src   = 4'(src);
    bus_if.acc_cnt_setup  = CNT_W'(setup);
    bus_if.mem_hit        = hit;
    bus_if.mem_rd_cnt     = CNT_W'(rcnt);
    bus_if.mem_rd_mask    = TILE_COUNT'(rmask);
  endtask

  task automatic idle();
    bus_if.acc_valid      = 1'b0;
    bus_if.acc_barrier_id = '0;
    bus_if.acc_tile_src   = '0;
    bus_if.acc_cnt_setup  = '0;
    bus_if.mem_hit        = 1'b0;
    bus_if.mem_rd_cnt     = '0;
    bus_if.mem_rd_mask    = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acc_ready"},   32'(bus_if.acc_ready),   0);
    chk({tag, "_rel_valid"},   32'(bus_if.rel_valid),   0);
    chk({tag, "_rel_id"},      32'(bus_if.rel_barrier_id), 0);
    chk({tag, "_rel_mask"},    32'(bus_if.rel_dest_mask),  0);
    chk({tag, "_mem_wr_en"},   32'(bus_if.mem_wr_en),   0);
    chk({tag, "_mem_wr_free"}, 32'(bus_if.mem_wr_free), 0);
    chk({tag, "_err_dup"},     32'(bus_if.err_dup),     0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus_if.rel_ready = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    cycle();
    chk("post_reset_acc_ready", 32'(bus_if.acc_ready), 1);

    // Single-tile immediate release
    drive_acc(9, 3, 0, 1'b0, 0, 0);
    cycle();
    chk("t1_wr_en",   32'(bus_if.mem_wr_en),   1);
    chk("t1_wr_cnt",  32'(bus_if.mem_wr_cnt),  0);
    chk("t1_wr_mask", 32'(bus_if.mem_wr_mask), 32'h0008);
    chk("t1_wr_free", 32'(bus_if.mem_wr_free), 1);
    chk("t1_rel_valid", 32'(bus_if.rel_valid), 1);
    chk("t1_rel_mask",  32'(bus_if.rel_dest_mask), 32'h0008);
    idle();
    cycle();
    chk("t1_wr_en_idle", 32'(bus_if.mem_wr_en), 0);

    // Four-tile barrier, back-to-back forwarding
    for (int i = 0; i < 4; i++) begin
      drive_acc(5, i, 3, 1'b0, 0, 0);
      cycle();
      chk("t2_wr_cnt", 32'(bus_if.mem_wr_cnt), 32'(3 - i));
      chk("t2_rel_valid", 32'(bus_if.rel_valid), 32'(i == 3));
    end
    chk("t2_wr_mask", 32'(bus_if.mem_wr_mask), 32'h000F);
    chk("t2_rel_id",  32'(bus_if.rel_barrier_id), 5);
    chk("t2_rel_mask", 32'(bus_if.rel_dest_mask), 32'h000F);
    idle();
    cycle();
    chk("t2_single_release", 32'(bus_if.rel_valid), 0);

    // Backpressure: fill the FIFO, hold an account while not ready, drain
    bus_if.rel_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_acc(10 + i, 4 + i, 0, 1'b0, 0, 0);
      cycle();
    end
    chk("t3_full_ready", 32'(bus_if.acc_ready), 0);
    drive_acc(14, 8, 0, 1'b0, 0, 0);
    cycle();
    cycle();
    chk("t3_held_no_write", 32'(bus_if.mem_wr_en), 0);
    idle();
    bus_if.rel_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_id",   32'(bus_if.rel_barrier_id), 32'(10 + i));
      chk("t3_drain_mask", 32'(bus_if.rel_dest_mask), 32'h0010 << i);
      cycle();
      if (i == 0) chk("t3_ready_after_pop", 32'(bus_if.acc_ready), 1);
    end
    chk("t3_drained", 32'(bus_if.rel_valid), 0);

    // Interleaved ids: no forwarding across different barriers
    drive_acc(1, 0, 0, 1'b1, 2, 0); cycle();
    drive_acc(2, 1, 0, 1'b1, 2, 0); cycle();
    drive_acc(1, 2, 0, 1'b1, 2, 0); cycle();
    chk("t4_id1_no_fwd_cnt",  32'(bus_if.mem_wr_cnt),  1);
    chk("t4_id1_no_fwd_mask", 32'(bus_if.mem_wr_mask), 32'h0004);
    // Forwarded freed entry counts as a miss despite a stale table hit
    drive_acc(7, 0, 0, 1'b1, 1, 0); cycle();
    chk("t4_id7_release", 32'(bus_if.mem_wr_free), 1);
    drive_acc(7, 2, 3, 1'b1, 1, 0); cycle();
    chk("t4_fwd_free_cnt",  32'(bus_if.mem_wr_cnt),  3);
    chk("t4_fwd_free_mask", 32'(bus_if.mem_wr_mask), 32'h0004);
    // Saturating decrement from zero
    drive_acc(8, 0, 0, 1'b1, 0, 32'h0100); cycle();
    chk("t4_sat_cnt",  32'(bus_if.mem_wr_cnt),  0);
    chk("t4_sat_mask", 32'(bus_if.mem_wr_mask), 32'h0101);
    chk("t4_sat_free", 32'(bus_if.mem_wr_free), 1);
    idle();
    repeat (3) cycle();

    // Reset mid-operation with two releases buffered
    bus_if.rel_ready = 1'b0;
    drive_acc(20, 1, 0, 1'b0, 0, 0); cycle();
    drive_acc(21, 2, 0, 1'b0, 0, 0); cycle();
    idle();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b1;
    bus_if.rel_ready = 1'b1;
    cycle();
    chk("midrst_rel_valid", 32'(bus_if.rel_valid), 0);
    chk("midrst_wr_en",     32'(bus_if.mem_wr_en), 0);
    chk("midrst_acc_ready", 32'(bus_if.acc_ready), 1);

    // Duplicate arrival
    drive_acc(30, 1, 0, 1'b1, 2, 32'h0002);
    cycle();
    if (DUP_EN) begin
      chk("t6_err_dup", 32'(bus_if.err_dup),   1);
      chk("t6_no_write", 32'(bus_if.mem_wr_en), 0);
    end else begin
      chk("t6_err_dup_off", 32'(bus_if.err_dup),     0);
      chk("t6_dec_cnt",     32'(bus_if.mem_wr_cnt),  1);
      chk("t6_dec_mask",    32'(bus_if.mem_wr_mask), 32'h0002);
    end
    chk("t6_no_release", 32'(bus_if.rel_valid), 0);
    idle();
    cycle();
    chk("t6_err_dup_pulse", 32'(bus_if.err_dup), 0);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
